// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU control stage: ALU opcode
// enumeration, RV32I major opcodes, and the funct3 -> ALU op mapping.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000,
        ALU_SUB  = 5'b00001,
        ALU_SLL  = 5'b00010,
        ALU_SLT  = 5'b00011,
        ALU_SLTU = 5'b00100,
        ALU_XOR  = 5'b00101,
        ALU_SRL  = 5'b00110,
        ALU_SRA  = 5'b00111,
        ALU_OR   = 5'b01000,
        ALU_AND  = 5'b01001,
        ALU_LUI  = 5'b01010
    } alu_op_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    // Map funct3 to the ALU op; alt selects SUB for 000 and SRA for 101.
    function automatic alu_op_t f3_to_op(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational RV32I decode of an instruction into ALU opcode, operand
// selects and an illegal flag. Illegal encodings force the reset opcode.
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter logic [4:0] RST_OP = 5'b00000
) (
    input  logic [31:0] instr,
    output alu_op_t     alu_op,
    output logic        sel_a_pc,
    output logic        sel_b_imm,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_bits;

    alu_op_t    raw_op;
    logic       raw_a;
    logic       raw_b;

    assign opcode      = instr[6:0];
    assign f3          = instr[14:12];
    assign f7          = instr[31:25];
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    // Raw field decode plus legality check per major opcode.
    always_comb begin
        raw_op  = ALU_ADD;
        raw_a   = 1'b0;
        raw_b   = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                raw_op  = f3_to_op(f3, f7[5]);
                illegal = !((f7 == F7_BASE) ||
                            ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OP_I: begin
                raw_b  = 1'b1;
                raw_op = f3_to_op(f3, (f3 == 3'b101) && f7[5]);
                if (f3 == 3'b001)
                    illegal = (f7 != F7_BASE);
                else if (f3 == 3'b101)
                    illegal = !((f7 == F7_BASE) || (f7 == F7_ALT));
            end
            OP_LUI: begin
                raw_op = ALU_LUI;
                raw_b  = 1'b1;
            end
            OP_AUIPC: begin
                raw_a = 1'b1;
                raw_b = 1'b1;
            end
            OP_LOAD, OP_STORE, OP_JALR: begin
                raw_b = 1'b1;
            end
            OP_JAL: begin
                raw_a = 1'b1;
            end
            OP_BRANCH: begin
                raw_op = ALU_SUB;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Illegal instructions carry neutral fields into Execute.
    always_comb begin
        alu_op    = raw_op;
        sel_a_pc  = raw_a;
        sel_b_imm = raw_b;
        if (illegal) begin
            alu_op    = alu_op_t'(RST_OP);
            sel_a_pc  = 1'b0;
            sel_b_imm = 1'b0;
        end
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX boundary for the ALU control fields: decodes the Decode-stage
// instruction and registers the result into Execute with flush/stall control.
module alu_ctrl_stage
    import alu_pkg::*;
#(
    parameter int         XLEN   = 32,
    parameter logic [4:0] RST_OP = 5'b00000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] instrD,
    input  logic            validD,
    input  logic            stallE,
    input  logic            flushE,
    output logic [4:0]      alu_opE,
    output logic            sel_a_pcE,
    output logic            sel_b_immE,
    output logic            validE,
    output logic            illegalE
);

    alu_op_t dec_op;
    logic    dec_a;
    logic    dec_b;
    logic    dec_ill;

    alu_op_decoder #(
        .RST_OP (RST_OP)
    ) u_dec (
        .instr     (instrD),
        .alu_op    (dec_op),
        .sel_a_pc  (dec_a),
        .sel_b_imm (dec_b),
        .illegal   (dec_ill)
    );

    // E-stage register: reset/flush bubble > stall hold > load (bubble if not valid).
    always_ff @(posedge clk) begin
        if (!rst_n || flushE) begin
            alu_opE    <= RST_OP;
            sel_a_pcE  <= 1'b0;
            sel_b_immE <= 1'b0;
            validE     <= 1'b0;
            illegalE   <= 1'b0;
        end else if (!stallE) begin
            if (validD) begin
                alu_opE    <= dec_op;
                sel_a_pcE  <= dec_a;
                sel_b_immE <= dec_b;
                validE     <= 1'b1;
                illegalE   <= dec_ill;
            end else begin
                alu_opE    <= RST_OP;
                sel_a_pcE  <= 1'b0;
                sel_b_immE <= 1'b0;
                validE     <= 1'b0;
                illegalE   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage with a behavioural reference model.
module tb_alu_ctrl_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] instrD;
    logic        validD;
    logic        stallE;
    logic        flushE;
    logic [4:0]  alu_opE;
    logic        sel_a_pcE;
    logic        sel_b_immE;
    logic        validE;
    logic        illegalE;

    int checks = 0;
    int errors = 0;

    // Model of the E-stage contents
    logic [4:0] m_op;
    logic       m_a, m_b, m_v, m_i;

    alu_ctrl_stage #(
        .XLEN   (32),
        .RST_OP (5'b00000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instrD     (instrD),
        .validD     (validD),
        .stallE     (stallE),
        .flushE     (flushE),
        .alu_opE    (alu_opE),
        .sel_a_pcE  (sel_a_pcE),
        .sel_b_immE (sel_b_immE),
        .validE     (validE),
        .illegalE   (illegalE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got=running required=finished");
        $fatal(1, "watchdog");
    end

    // Reference decode: returns {illegal, sel_a_pc, sel_b_imm, op[4:0]}.
    function automatic logic [7:0] ref_dec(input logic [31:0] ins);
        int         base [0:7];
        logic [6:0] opc;
        int         f3;
        logic [6:0] f7;
        int         op;
        logic       a, b, ill;
        base = '{0, 2, 3, 4, 5, 6, 8, 9};
        opc  = ins[6:0];
        f3   = int'(ins[14:12]);
        f7   = ins[31:25];
        op = 0; a = 0; b = 0; ill = 0;
        case (opc)
            7'h33: begin
                if (f7 == 7'h00) op = base[f3];
                else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) op = base[f3] + 1;
                else ill = 1;
            end
            7'h13: begin
                b  = 1;
                op = base[f3];
                if (f3 == 1 && f7 != 7'h00) ill = 1;
                if (f3 == 5) begin
                    if (f7 == 7'h20) op = op + 1;
                    else if (f7 != 7'h00) ill = 1;
                end
            end
            7'h37: begin op = 10; b = 1; end
            7'h17: begin a = 1; b = 1; end
            7'h03, 7'h23, 7'h67: b = 1;
            7'h6F: a = 1;
            7'h63: op = 1;
            default: ill = 1;
        endcase
        if (ill) begin op = 0; a = 0; b = 0; end
        return {ill, a, b, op[4:0]};
    endfunction

    function automatic logic [8:0] exp_vec();
        return {m_op, m_a, m_b, m_v, m_i};
    endfunction

    // Advance the model with the current inputs, then step one clock.
    task automatic cycle();
        logic [7:0] d;
        d = ref_dec(instrD);
        if (!rst_n || flushE || (!stallE && !validD)) begin
            m_op = 5'd0; m_a = 0; m_b = 0; m_v = 0; m_i = 0;
        end else if (!stallE) begin
            m_op = d[4:0]; m_b = d[5]; m_a = d[6]; m_v = 1'b1; m_i = d[7];
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [0:9];
        logic [31:0] r;
        int k;
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h63, 7'h00};
        r = $urandom;
        k = $urandom_range(0, 9);
        r[6:0] = (k == 9) ? 7'($urandom) : opcs[k];
        case ($urandom_range(0, 2))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 0; validD = 1; instrD = 32'h40000033; stallE = 0; flushE = 0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if ({alu_opE, sel_a_pcE, sel_b_immE, validE, illegalE} !== 9'b0) begin
                errors++;
                $display("FAIL reset cyc=%0d got=%b required=%b", i,
                         {alu_opE, sel_a_pcE, sel_b_immE, validE, illegalE}, 9'b0);
            end
        end
        rst_n = 1;
        #1;
        checks++;
        if (alu_opE !== 5'b00000 || validE !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got op=%b v=%b required op=00000 v=0", alu_opE, validE);
        end
        cycle();
        checks++;
        if (alu_opE !== 5'b00001 || validE !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_load got op=%b v=%b required op=00001 v=1", alu_opE, validE);
        end
    endtask

    task automatic test_sweep();
        logic [6:0] f7s [0:1];
        f7s = '{7'h00, 7'h20};
        validD = 1;
        for (int opi = 0; opi < 2; opi++) begin
            for (int f3 = 0; f3 < 8; f3++) begin
                for (int j = 0; j < 3; j++) begin
                    instrD = $urandom;
                    instrD[6:0]   = (opi == 0) ? 7'h33 : 7'h13;
                    instrD[14:12] = 3'(f3);
                    if (j < 2) instrD[31:25] = f7s[j];
                    cycle();
                    checks++;
                    if ({alu_opE, sel_a_pcE, sel_b_immE, validE, illegalE} !== exp_vec()) begin
                        errors++;
                        $display("FAIL sweep instr=%h got=%b required=%b", instrD,
                                 {alu_opE, sel_a_pcE, sel_b_immE, validE, illegalE}, exp_vec());
                    end
                end
            end
        end
        instrD = 32'h40005033;
        cycle();
        checks++;
        if (alu_opE !== 5'b00111 || sel_b_immE !== 1'b0 || illegalE !== 1'b0) begin
            errors++;
            $display("FAIL sra got op=%b b=%b ill=%b required op=00111 b=0 ill=0",
                     alu_opE, sel_b_immE, illegalE);
        end
        instrD = 32'h4000D013;
        cycle();
        checks++;
        if (alu_opE !== 5'b00111 || sel_b_immE !== 1'b1 || illegalE !== 1'b0) begin
            errors++;
            $display("FAIL srai got op=%b b=%b ill=%b required op=00111 b=1 ill=0",
                     alu_opE, sel_b_immE, illegalE);
        end
    endtask

    task automatic test_uj_mem();
        logic [31:0] ins [0:3];
        logic [6:0]  want [0:3];
        ins  = '{32'h000000B7, 32'h00000097, 32'h0000006F, 32'h00000063};
        want = '{{5'b01010, 2'b01}, {5'b00000, 2'b11}, {5'b00000, 2'b10}, {5'b00001, 2'b00}};
        validD = 1;
        for (int i = 0; i < 4; i++) begin
            instrD = ins[i];
            cycle();
            checks++;
            if ({alu_opE, sel_a_pcE, sel_b_immE} !== want[i] || validE !== 1'b1 || illegalE !== 1'b0) begin
                errors++;
                $display("FAIL uj_mem instr=%h got=%b v=%b ill=%b required=%b v=1 ill=0",
                         ins[i], {alu_opE, sel_a_pcE, sel_b_immE}, validE, illegalE, want[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ins [0:1];
        ins = '{32'h20000033, 32'h0000007F};
        for (int v = 1; v >= 0; v--) begin
            for (int i = 0; i < 2; i++) begin
                instrD = 32'h00006033;   // OR first, so a stale nonzero op would show
                validD = 1;
                cycle();
                instrD = ins[i];
                validD = v[0];
                cycle();
                checks++;
                if ({alu_opE, sel_a_pcE, sel_b_immE, validE, illegalE} !== {7'b0, v[0], v[0]}) begin
                    errors++;
                    $display("FAIL illegal instr=%h validD=%0d got=%b required=%b", ins[i], v,
                             {alu_opE, sel_a_pcE, sel_b_immE, validE, illegalE}, {7'b0, v[0], v[0]});
                end
            end
        end
    endtask

    task automatic test_stall_flush();
        validD = 1; stallE = 0; flushE = 0;
        instrD = 32'h00004033;
        cycle();
        instrD = 32'h00007033;
        stallE = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (alu_opE !== 5'b00101 || validE !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got op=%b v=%b required op=00101 v=1", i, alu_opE, validE);
            end
        end
        flushE = 1;
        cycle();
        checks++;
        if ({alu_opE, sel_a_pcE, sel_b_immE, validE, illegalE} !== 9'b0) begin
            errors++;
            $display("FAIL stall_flush got=%b required=%b",
                     {alu_opE, sel_a_pcE, sel_b_immE, validE, illegalE}, 9'b0);
        end
        stallE = 0; flushE = 0;
        cycle();
        checks++;
        if (alu_opE !== 5'b01001 || validE !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got op=%b v=%b required op=01001 v=1", alu_opE, validE);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [0:3];
        logic [4:0]  want [0:3];
        ins  = '{32'h00000033, 32'h40000033, 32'h00002033, 32'h000000B7};
        want = '{5'b00000, 5'b00001, 5'b00011, 5'b01010};
        validD = 1; stallE = 0; flushE = 0;
        instrD = 32'h00006033;
        cycle();
        for (int i = 0; i < 4; i++) begin
            instrD = ins[i];
            #1;
            checks++;
            if (alu_opE !== ((i == 0) ? 5'b01000 : want[i-1])) begin
                errors++;
                $display("FAIL b2b_before idx=%0d got=%b required=%b", i, alu_opE,
                         (i == 0) ? 5'b01000 : want[i-1]);
            end
            cycle();
            checks++;
            if (alu_opE !== want[i]) begin
                errors++;
                $display("FAIL b2b idx=%0d got=%b required=%b", i, alu_opE, want[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst_n  = ($urandom_range(0, 49) != 0);
            validD = ($urandom_range(0, 3) != 0);
            stallE = ($urandom_range(0, 4) == 0);
            flushE = ($urandom_range(0, 7) == 0);
            instrD = rand_instr();
            cycle();
            checks++;
            if ({alu_opE, sel_a_pcE, sel_b_immE, validE, illegalE} !== exp_vec()) begin
                errors++;
                $display("FAIL random n=%0d instr=%h rst_n=%b vD=%b st=%b fl=%b got=%b required=%b",
                         n, instrD, rst_n, validD, stallE, flushE,
                         {alu_opE, sel_a_pcE, sel_b_immE, validE, illegalE}, exp_vec());
            end
            // Outputs must not move when inputs change between edges.
            instrD = rand_instr();
            validD = ~validD;
            flushE = ~flushE;
            #2;
            checks++;
            if ({alu_opE, sel_a_pcE, sel_b_immE, validE, illegalE} !== exp_vec()) begin
                errors++;
                $display("FAIL comb_path n=%0d got=%b required=%b", n,
                         {alu_opE, sel_a_pcE, sel_b_immE, validE, illegalE}, exp_vec());
            end
        end
        rst_n = 1; stallE = 0; flushE = 0;
    endtask

    initial begin
        m_op = '0; m_a = 0; m_b = 0; m_v = 0; m_i = 0;
        rst_n = 0; instrD = '0; validD = 0; stallE = 0; flushE = 0;
        test_reset();
        test_sweep();
        test_uj_mem();
        test_illegal();
        test_stall_flush();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
